// File: rtl/multi_block_controller.sv
// Platform row manager for the jump game: fills the row on init, then scrolls, shifts and
// spawns a new platform on each reload, handshaking with the main FSM through reload_done.
module multi_block_controller #(
   parameter int NUM_BLOCKS  = 4,
   parameter int XW          = 32,
   parameter int RAND_W      = 7,
   parameter int X_HOME      = 100,
   parameter int GAP_MIN     = 80,
   parameter int SCROLL_STEP = 4,
   parameter logic [2:0] ST_INIT   = 3'd0,
   parameter logic [2:0] ST_RELOAD = 3'd3
) (
   input  logic                       clk_machine,
   input  logic                       rst_machine,
   input  logic [2:0]                 state,
   input  logic [RAND_W-1:0]          random,
   output logic [NUM_BLOCKS*XW-1:0]   o_x_block,
   output logic [NUM_BLOCKS-1:0]      o_en_block,
   output logic                       reload_done,
   output logic                       busy
);

   localparam int IDXW = (NUM_BLOCKS > 2) ? $clog2(NUM_BLOCKS) : 1;

   typedef enum logic [2:0] {IDLE, FILL, SCROLL, SHIFT, DONE} fsm_t;

   fsm_t                  fsm_q, fsm_d;
   logic [2:0]            state_q, trig_q, trig_d;
   logic [IDXW-1:0]       idx_q, idx_d;
   logic [XW-1:0]         rem_q, rem_d, rem_init, step;
   logic [XW-1:0]         x_q [NUM_BLOCKS];
   logic [XW-1:0]         x_d [NUM_BLOCKS];
   logic [NUM_BLOCKS-1:0] en_q, en_d;
   logic                  done_q, done_d, busy_d;
   logic                  start_init, start_reload;

   function automatic logic [XW-1:0] sat_add(input logic [XW-1:0] a, input logic [RAND_W-1:0] r);
      logic [XW:0] s;
      s = {1'b0, a} + (XW+1)'(GAP_MIN) + (XW+1)'(r);
      return s[XW] ? {XW{1'b1}} : s[XW-1:0];
   endfunction

   function automatic logic [XW-1:0] sat_sub(input logic [XW-1:0] a, input logic [XW-1:0] b);
      return (a > b) ? (a - b) : '0;
   endfunction

   assign start_init   = (state == ST_INIT)   && (state_q != ST_INIT);
   assign start_reload = (state == ST_RELOAD) && (state_q != ST_RELOAD);
   assign rem_init     = sat_sub(x_q[1], XW'(X_HOME));
   assign step         = (rem_q < XW'(SCROLL_STEP)) ? rem_q : XW'(SCROLL_STEP);

   always_comb begin
      fsm_d  = fsm_q;
      trig_d = trig_q;
      idx_d  = idx_q;
      rem_d  = rem_q;
      x_d    = x_q;
      en_d   = en_q;
      done_d = done_q;
      case (fsm_q)
         IDLE: begin
            if (start_init) begin
               fsm_d  = FILL;
               trig_d = ST_INIT;
               idx_d  = IDXW'(1);
               x_d[0] = XW'(X_HOME);
               en_d   = NUM_BLOCKS'(1);
            end else if (start_reload) begin
               // A row whose next platform is already at or left of home skips scrolling.
               trig_d = ST_RELOAD;
               rem_d  = rem_init;
               fsm_d  = (rem_init == '0) ? SHIFT : SCROLL;
            end
         end
         FILL: begin
            x_d[idx_q]  = sat_add(x_q[idx_q - IDXW'(1)], random);
            en_d[idx_q] = 1'b1;
            idx_d       = idx_q + IDXW'(1);
            if (idx_q == IDXW'(NUM_BLOCKS-1)) begin
               fsm_d  = DONE;
               done_d = (state == trig_q);
            end
         end
         SCROLL: begin
            if (rem_q == '0) begin
               fsm_d = SHIFT;
            end else begin
               for (int i = 0; i < NUM_BLOCKS; i++) begin
                  if (en_q[i]) x_d[i] = sat_sub(x_q[i], step);
               end
               rem_d = rem_q - step;
               if (rem_q == step) fsm_d = SHIFT;
            end
         end
         SHIFT: begin
            for (int i = 0; i < NUM_BLOCKS-1; i++) begin
               x_d[i]  = x_q[i+1];
               en_d[i] = en_q[i+1];
            end
            x_d[NUM_BLOCKS-1]  = sat_add(x_q[NUM_BLOCKS-1], random);
            en_d[NUM_BLOCKS-1] = 1'b1;
            fsm_d  = DONE;
            done_d = (state == trig_q);
         end
         DONE: begin
            // An aborted sequence arrives here with the state already changed and leaves at once.
            if (state != trig_q) begin
               fsm_d  = IDLE;
               done_d = 1'b0;
            end else begin
               done_d = 1'b1;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   assign busy_d = (fsm_d == FILL) || (fsm_d == SCROLL) || (fsm_d == SHIFT);

   always_ff @(posedge clk_machine or posedge rst_machine) begin
      if (rst_machine) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         trig_q  <= '0;
         idx_q   <= '0;
         rem_q   <= '0;
         for (int i = 0; i < NUM_BLOCKS; i++) x_q[i] <= (i == 0) ? XW'(X_HOME) : '0;
         en_q    <= NUM_BLOCKS'(1);
         done_q  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state;
         trig_q  <= trig_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         x_q     <= x_d;
         en_q    <= en_d;
         done_q  <= done_d;
         busy    <= busy_d;
      end
   end

   always_comb begin
      o_x_block = '0;
      for (int i = 0; i < NUM_BLOCKS; i++) o_x_block[i*XW +: XW] = x_q[i];
   end

   assign o_en_block  = en_q;
   assign reload_done = done_q;

endmodule

// File: tb/tb_multi_block_controller.sv
// Bench for multi_block_controller: directed table, reset/abort corner cases, a randomized
// sequence run against a row-level reference model, and a narrow-width saturation instance.
module tb_multi_block_controller;

   localparam longint MAXX = 64'h0000_0000_FFFF_FFFF;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   st, st2;
   logic [6:0]   rnd, rnd2;
   logic [127:0] ox;
   logic [39:0]  ox2;
   logic [3:0]   oen, oen2;
   logic         rd, rd2, bsy, bsy2;

   int     tests = 0;
   int     fails = 0;
   longint mx [4];
   int     men;

   typedef struct {
      int     code;
      int     r;
      int     abort_at;
      longint ex [4];
      int     een;
      int     ecyc;
      int     edone;
   } vec_t;

   vec_t vecs [5];

   multi_block_controller dut (
      .clk_machine(clk), .rst_machine(rst), .state(st), .random(rnd),
      .o_x_block(ox), .o_en_block(oen), .reload_done(rd), .busy(bsy)
   );

   multi_block_controller #(.XW(10), .X_HOME(800)) dut2 (
      .clk_machine(clk), .rst_machine(rst), .state(st2), .random(rnd2),
      .o_x_block(ox2), .o_en_block(oen2), .reload_done(rd2), .busy(bsy2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic longint msat(input longint v);
      return (v > MAXX) ? MAXX : v;
   endfunction

   // Row-level model: an init rebuilds the whole row, a reload moves every visible platform
   // left by the full distance at once, then drops the front one and spawns at the back.
   task automatic model_step(input int code, input int r, output int ecyc);
      longint rem, last;
      if (code == 0) begin
         mx[0] = 100;
         for (int i = 1; i < 4; i++) mx[i] = msat(mx[i-1] + 80 + r);
         men  = 15;
         ecyc = 3;
      end else begin
         rem = (mx[1] > 100) ? mx[1] - 100 : 0;
         for (int i = 0; i < 4; i++)
            if (men[i]) mx[i] = (mx[i] > rem) ? mx[i] - rem : 0;
         last = mx[3];
         for (int i = 0; i < 3; i++) mx[i] = mx[i+1];
         mx[3] = msat(last + 80 + r);
         men   = (men >> 1) | 8;
         ecyc  = (rem == 0) ? 1 : int'((rem + 3) / 4) + 1;
      end
   endtask

   task automatic apply_stimulus(input int code, input int r, input int abort_at,
                                 output int cyc, output logic done_seen, output logic to);
      rnd = 7'(r);
      st  = 3'(code);
      tick();
      cyc       = 0;
      done_seen = 1'b0;
      while (bsy === 1'b1 && cyc < 200) begin
         cyc++;
         if (rd !== 1'b0) done_seen = 1'b1;
         if (abort_at > 0 && cyc == abort_at) st = 3'd1;
         tick();
      end
      to = (cyc >= 200);
   endtask

   task automatic run_and_check(input string tag, input int code, input int r, input int abort_at,
                                input longint ex [4], input int een, input int ecyc, input int edone);
      int   cyc;
      logic seen, to;
      apply_stimulus(code, r, abort_at, cyc, seen, to);
      check_output({tag, " timeout"}, 64'(to), 64'd0);
      check_output({tag, " busy_cycles"}, 64'(cyc), 64'(ecyc));
      check_output({tag, " done_while_busy"}, 64'(seen), 64'd0);
      check_output({tag, " reload_done"}, 64'(rd), 64'(edone));
      for (int i = 0; i < 4; i++)
         check_output($sformatf("%s x%0d", tag, i), 64'(ox[i*32 +: 32]), 64'(ex[i]));
      check_output({tag, " en"}, 64'(oen), 64'(een));
      st = 3'd2;
      tick();
      check_output({tag, " done_released"}, 64'(rd), 64'd0);
      check_output({tag, " idle_busy"}, 64'(bsy), 64'd0);
   endtask

   initial begin
      int     mc, ab, code, r;
      longint ex [4];
      int     c;

      vecs[0] = '{0, 20, 0, '{100, 200, 300, 400}, 15, 3, 1};
      vecs[1] = '{3, 10, 0, '{100, 200, 300, 390}, 15, 26, 1};
      vecs[2] = '{0, 26, 0, '{100, 206, 312, 418}, 15, 3, 1};
      vecs[3] = '{3, 26, 0, '{100, 206, 312, 418}, 15, 28, 1};
      vecs[4] = '{3, 5, 3, '{100, 206, 312, 397}, 15, 28, 0};

      rst = 1'b1; st = 3'd2; rnd = '0; st2 = 3'd2; rnd2 = '0;
      repeat (2) @(posedge clk);
      #1;
      check_output("reset x0", 64'(ox[31:0]), 64'd100);
      check_output("reset x1to3", 64'(ox[127:32] != '0), 64'd0);
      check_output("reset en", 64'(oen), 64'd1);
      check_output("reset done", 64'(rd), 64'd0);
      check_output("reset busy", 64'(bsy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      mx = '{100, 0, 0, 0};
      men = 1;

      for (int k = 0; k < 5; k++) begin
         model_step(vecs[k].code, vecs[k].r, mc);
         run_and_check($sformatf("vec%0d", k), vecs[k].code, vecs[k].r, vecs[k].abort_at,
                       vecs[k].ex, vecs[k].een, vecs[k].ecyc, vecs[k].edone);
      end

      // Asynchronous reset landing in the middle of a scroll.
      rnd = '0;
      st  = 3'd3;
      tick();
      repeat (5) tick();
      check_output("pre_reset busy", 64'(bsy), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check_output("async_rst x0", 64'(ox[31:0]), 64'd100);
      check_output("async_rst x1to3", 64'(ox[127:32] != '0), 64'd0);
      check_output("async_rst en", 64'(oen), 64'd1);
      check_output("async_rst done", 64'(rd), 64'd0);
      check_output("async_rst busy", 64'(bsy), 64'd0);
      st = 3'd2;
      @(negedge clk);
      rst = 1'b0;
      tick();
      mx = '{100, 0, 0, 0};
      men = 1;

      for (int k = 0; k < 40; k++) begin
         code = ($urandom_range(0, 2) == 0) ? 0 : 3;
         r    = int'($urandom_range(0, 127));
         ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         model_step(code, r, mc);
         ex = mx;
         run_and_check($sformatf("rand%0d", k), code, r, ab, ex, men, mc,
                       (ab > 0 && ab <= mc) ? 0 : 1);
      end

      // Narrow coordinates: the row must pin at 1023 rather than wrap.
      rnd2 = 7'd127;
      st2  = 3'd0;
      tick();
      c = 0;
      while (bsy2 === 1'b1 && c < 50) begin c++; tick(); end
      check_output("sat init cycles", 64'(c), 64'd3);
      check_output("sat init x1", 64'(ox2[19:10]), 64'd1007);
      check_output("sat init x2", 64'(ox2[29:20]), 64'd1023);
      check_output("sat init x3", 64'(ox2[39:30]), 64'd1023);
      check_output("sat init done", 64'(rd2), 64'd1);
      st2 = 3'd2;
      tick();
      st2 = 3'd3;
      tick();
      c = 0;
      while (bsy2 === 1'b1 && c < 100) begin c++; tick(); end
      check_output("sat reload cycles", 64'(c), 64'd53);
      check_output("sat reload x0", 64'(ox2[9:0]), 64'd800);
      check_output("sat reload x1", 64'(ox2[19:10]), 64'd816);
      check_output("sat reload x2", 64'(ox2[29:20]), 64'd816);
      check_output("sat reload x3", 64'(ox2[39:30]), 64'd1023);
      check_output("sat reload done", 64'(rd2), 64'd1);
      st2 = 3'd2;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
